// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-port synchronous RAM between instruction fetch and data.
// Data wins by default; a wait counter bounds how long a pending fetch can be starved.
module mem_arbiter #(
  parameter int unsigned AW       = 10,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [31:0]   i_addr,
  output logic          i_ready,
  output logic [31:0]   i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [31:0]   d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_ready,
  output logic [31:0]   d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  typedef enum logic [1:0] {StIdle, StAccI, StAccD} state_e;

  state_e     state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic       d_we_q, d_we_d;
  logic       grant_i, grant_d;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[31:AW+2], i_addr[1:0], d_addr[31:AW+2], d_addr[1:0]};

  // Grants are gated by reset so the RAM never sees a strobe while held in reset.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (reset && (state_q == StIdle)) begin
      if (d_req && !(i_req && (wait_q == MaxWait))) begin
        grant_d = 1'b1;
      end else if (i_req) begin
        grant_i = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      wait_q  <= '0;
      d_we_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      d_we_q  <= d_we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    d_we_d  = d_we_q;
    unique case (state_q)
      StIdle: begin
        if (grant_d) begin
          state_d = StAccD;
          d_we_d  = d_we;
        end else if (grant_i) begin
          state_d = StAccI;
        end
        if (grant_i || !i_req) begin
          wait_d = '0;
        end else if (grant_d && (wait_q < MaxWait)) begin
          wait_d = wait_q + 4'd1;
        end
      end
      StAccI, StAccD: state_d = StIdle;
      default:        state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_en    = grant_i | grant_d;
    mem_we    = grant_d & d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_d) begin
      mem_addr  = d_addr[AW+1:2];
      mem_wdata = d_wdata;
    end else if (grant_i) begin
      mem_addr = i_addr[AW+1:2];
    end
    i_ready = reset && (state_q == StAccI);
    d_ready = reset && (state_q == StAccD);
    i_rdata = i_ready ? mem_rdata : '0;
    // Write completions return zero data; the access type was latched at issue.
    d_rdata = (d_ready && !d_we_q) ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model with a shadow memory.
module tb_mem_arbiter;

  localparam int unsigned AW       = 10;
  localparam int unsigned MAX_WAIT = 4;

  logic          clk;
  logic          reset;
  logic          i_req;
  logic [31:0]   i_addr;
  logic          i_ready;
  logic [31:0]   i_rdata;
  logic          d_req;
  logic          d_we;
  logic [31:0]   d_addr;
  logic [31:0]   d_wdata;
  logic          d_ready;
  logic [31:0]   d_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram    [0:1023];
  logic [31:0] shadow [0:15];

  mem_arbiter #(.AW(AW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_ready   (i_ready),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ready   (d_ready),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Environment RAM: synchronous, read-before-write, data valid one cycle after the strobe.
  always @(posedge clk) begin
    logic [31:0] rd;
    if (mem_en) begin
      rd = ram[mem_addr];
      if (mem_we) ram[mem_addr] = mem_wdata;
      mem_rdata <= rd;
    end
  end

  function automatic logic [31:0] rand_addr(input int w);
    return ({$urandom} & 32'hFFFF_F000) | (32'(w) << 2) | ({$urandom} & 32'h3);
  endfunction

  task automatic idle_all();
    @(posedge clk); #1;
    i_req = 1'b0;
    d_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] exp17;
    reset = 1'b0; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    i_addr = 32'h20; d_addr = 32'h44; d_wdata = 32'hA5A5_5A5A;
    repeat (2) @(negedge clk);
    checks++;
    if ({i_ready, d_ready, i_rdata, d_rdata, mem_we, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %0h required 0",
               {i_ready, d_ready, i_rdata, d_rdata, mem_we, mem_addr, mem_wdata});
    end
    checks++;
    if (mem_en !== 1'b0) begin
      errors++; $display("FAIL reset_mem_en got %0b required 0", mem_en);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 10'd17}) begin
      errors++;
      $display("FAIL reset_first_grant got en=%0b we=%0b addr=%0d required 1/0/17",
               mem_en, mem_we, mem_addr);
    end
    exp17 = ram[17];
    @(negedge clk);
    checks++;
    if ({i_ready, d_ready, d_rdata} !== {1'b0, 1'b1, exp17}) begin
      errors++;
      $display("FAIL reset_first_ready got i=%0b d=%0b data=%0h required 0/1/%0h",
               i_ready, d_ready, d_rdata, exp17);
    end
    idle_all();
  endtask

  task automatic test_lone_fetch();
    ram[3] = 32'hDEAD_BEEF;
    i_req = 1'b1; i_addr = 32'h0000_000C;
    @(negedge clk);
    checks++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 10'd3}) begin
      errors++;
      $display("FAIL fetch_issue got en=%0b we=%0b addr=%0d required 1/0/3", mem_en, mem_we,
               mem_addr);
    end
    @(negedge clk);
    checks++;
    if ({i_ready, i_rdata, mem_en} !== {1'b1, 32'hDEAD_BEEF, 1'b0}) begin
      errors++;
      $display("FAIL fetch_ready got rdy=%0b data=%0h en=%0b required 1/deadbeef/0",
               i_ready, i_rdata, mem_en);
    end
    @(posedge clk); #1;
    i_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({i_ready, i_rdata, mem_en} !== '0) begin
      errors++;
      $display("FAIL fetch_idle got rdy=%0b data=%0h en=%0b required 0", i_ready, i_rdata, mem_en);
    end
    idle_all();
  endtask

  task automatic test_write_readback();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'h1234_5678;
    @(negedge clk);
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 10'd4, 32'h1234_5678}) begin
      errors++;
      $display("FAIL wr_issue got en=%0b we=%0b addr=%0d wdata=%0h required 1/1/4/12345678",
               mem_en, mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk);
    checks++;
    if ({d_ready, d_rdata} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL wr_ready got rdy=%0b data=%0h required 1/0", d_ready, d_rdata);
    end
    @(posedge clk); #1;
    d_we = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 10'd4}) begin
      errors++;
      $display("FAIL rd_issue got en=%0b we=%0b addr=%0d required 1/0/4", mem_en, mem_we, mem_addr);
    end
    @(negedge clk);
    checks++;
    if ({d_ready, d_rdata} !== {1'b1, 32'h1234_5678}) begin
      errors++;
      $display("FAIL rd_back got rdy=%0b data=%0h required 1/12345678", d_ready, d_rdata);
    end
    idle_all();
  endtask

  task automatic test_collision();
    logic [31:0] exp_i, exp_d;
    exp_i = ram[12]; exp_d = ram[21];
    i_req = 1'b1; i_addr = 32'h30; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h54;
    @(negedge clk);
    checks++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 10'd21}) begin
      errors++;
      $display("FAIL coll_d_issue got en=%0b addr=%0d required 1/21", mem_en, mem_addr);
    end
    @(negedge clk);
    checks++;
    if ({i_ready, d_ready, d_rdata} !== {1'b0, 1'b1, exp_d}) begin
      errors++;
      $display("FAIL coll_d_ready got i=%0b d=%0b data=%0h required 0/1/%0h", i_ready, d_ready,
               d_rdata, exp_d);
    end
    @(posedge clk); #1;
    d_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 10'd12}) begin
      errors++;
      $display("FAIL coll_i_issue got en=%0b addr=%0d required 1/12", mem_en, mem_addr);
    end
    @(negedge clk);
    checks++;
    if ({i_ready, d_ready, i_rdata} !== {1'b1, 1'b0, exp_i}) begin
      errors++;
      $display("FAIL coll_i_ready got i=%0b d=%0b data=%0h required 1/0/%0h", i_ready, d_ready,
               i_rdata, exp_i);
    end
    idle_all();
  endtask

  // Fetch held, data re-requesting every idle cycle: expect MAX_WAIT data grants per fetch grant.
  task automatic test_starvation();
    logic exp_i;
    i_req = 1'b1; i_addr = 32'h100; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    for (int g = 0; g < 2 * (MAX_WAIT + 1); g++) begin
      exp_i = ((g % (MAX_WAIT + 1)) == MAX_WAIT);
      @(negedge clk);
      checks++;
      if ({mem_en, mem_addr} !== {1'b1, exp_i ? 10'd64 : 10'd128}) begin
        errors++;
        $display("FAIL starve_grant%0d got en=%0b addr=%0d required 1/%0d", g, mem_en, mem_addr,
                 exp_i ? 64 : 128);
      end
      @(negedge clk);
      checks++;
      if ({i_ready, d_ready} !== {exp_i, !exp_i}) begin
        errors++;
        $display("FAIL starve_ready%0d got i=%0b d=%0b required %0b/%0b", g, i_ready, d_ready,
                 exp_i, !exp_i);
      end
    end
    idle_all();
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] exp;
    exp = ram[18];
    i_req = 1'b1; i_addr = 32'h48;
    @(negedge clk);
    checks++;
    if ({mem_en, mem_addr} !== {1'b1, 10'd18}) begin
      errors++; $display("FAIL mid_issue got en=%0b addr=%0d required 1/18", mem_en, mem_addr);
    end
    @(posedge clk); #1;
    checks++;
    if (i_ready !== 1'b1) begin
      errors++; $display("FAIL mid_acc got rdy=%0b required 1", i_ready);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({i_ready, i_rdata, mem_en} !== '0) begin
      errors++;
      $display("FAIL mid_abort got rdy=%0b data=%0h en=%0b required 0", i_ready, i_rdata, mem_en);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({mem_en, mem_addr} !== {1'b1, 10'd18}) begin
      errors++; $display("FAIL mid_reissue got en=%0b addr=%0d required 1/18", mem_en, mem_addr);
    end
    @(negedge clk);
    checks++;
    if ({i_ready, i_rdata} !== {1'b1, exp}) begin
      errors++;
      $display("FAIL mid_ready got rdy=%0b data=%0h required 1/%0h", i_ready, i_rdata, exp);
    end
    idle_all();
  endtask

  task automatic test_random();
    int   busy;   // 0 idle, 1 fetch in flight, 2 data in flight
    int   streak; // data wins while a fetch has been waiting
    int   i_w, d_w;
    bit   i_done, d_done, gi, gd, exp_dwe;
    logic [31:0] exp_data;
    for (int k = 0; k < 16; k++) shadow[k] = ram[k];
    busy = 0; streak = 0; i_done = 1'b0; d_done = 1'b0; i_w = 0; d_w = 0;
    exp_data = '0; exp_dwe = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (!i_req || i_done) begin
        i_req = 1'($urandom_range(1, 0));
        i_w = $urandom_range(15, 0);
        i_addr = rand_addr(i_w);
      end
      if (!d_req || d_done) begin
        d_req = 1'($urandom_range(1, 0));
        d_w = $urandom_range(15, 0);
        d_addr = rand_addr(d_w);
        d_we = 1'($urandom_range(1, 0));
        d_wdata = $urandom;
      end
      i_done = 1'b0; d_done = 1'b0;
      @(negedge clk);
      if (busy == 0) begin
        gd = d_req && !(i_req && (streak == MAX_WAIT));
        gi = i_req && !gd;
        checks++;
        if ({i_ready, d_ready, mem_en} !== {1'b0, 1'b0, gi | gd}) begin
          errors++;
          $display("FAIL rnd_idle c=%0d got i=%0b d=%0b en=%0b required 0/0/%0b", c, i_ready,
                   d_ready, mem_en, gi | gd);
        end
        if (gd) begin
          checks++;
          if ({mem_we, mem_addr, mem_wdata} !== {d_we, 10'(d_w), d_wdata}) begin
            errors++;
            $display("FAIL rnd_d_issue c=%0d got we=%0b addr=%0d wd=%0h required %0b/%0d/%0h", c,
                     mem_we, mem_addr, mem_wdata, d_we, d_w, d_wdata);
          end
          exp_dwe = d_we;
          exp_data = d_we ? 32'h0 : shadow[d_w];
          if (d_we) shadow[d_w] = d_wdata;
          if (i_req && streak < MAX_WAIT) streak++;
          busy = 2;
        end else if (gi) begin
          checks++;
          if ({mem_we, mem_addr, mem_wdata} !== {1'b0, 10'(i_w), 32'h0}) begin
            errors++;
            $display("FAIL rnd_i_issue c=%0d got we=%0b addr=%0d wd=%0h required 0/%0d/0", c,
                     mem_we, mem_addr, mem_wdata, i_w);
          end
          exp_data = shadow[i_w];
          streak = 0;
          busy = 1;
        end
        if (!i_req) streak = 0;
      end else begin
        checks++;
        if ({mem_en, i_ready, d_ready} !== {1'b0, busy == 1, busy == 2}) begin
          errors++;
          $display("FAIL rnd_done c=%0d got en=%0b i=%0b d=%0b required 0/%0b/%0b", c, mem_en,
                   i_ready, d_ready, busy == 1, busy == 2);
        end
        checks++;
        if ((busy == 1 && i_rdata !== exp_data) || (busy == 2 && d_rdata !== exp_data)) begin
          errors++;
          $display("FAIL rnd_data c=%0d got %0h required %0h (dwrite=%0b)", c,
                   busy == 1 ? i_rdata : d_rdata, exp_data, exp_dwe);
        end
        i_done = (busy == 1);
        d_done = (busy == 2);
        busy = 0;
      end
    end
    idle_all();
  endtask

  initial begin
    for (int k = 0; k < 1024; k++) ram[k] = $urandom;
    mem_rdata = '0;
    test_reset();
    test_lone_fetch();
    test_write_readback();
    test_collision();
    test_starvation();
    test_reset_mid_access();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares one single-port synchronous word RAM between the `rv32i` instruction-fetch port and its data port. It sits between the core and a unified `ram`-style memory, so programs and data live in the same array. The data port wins by default. A grant counter prevents instruction-fetch starvation. Every access takes exactly two cycles: issue, then complete.

## Interface
Parameters:
- `AW`, default 10: word-address width of the shared RAM (1024 words).
- `MAX_WAIT`, default 4: maximum consecutive data grants while a fetch is pending; range 1..15.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `i_req`  in  1  fetch request; held high until `i_ready`.
- `i_addr`  in  32  fetch byte address.
- `i_ready`  out  1  one-cycle completion pulse for the fetch.
- `i_rdata`  out  32  fetch data; valid only while `i_ready`=1, otherwise 0.
- `d_req`  in  1  data request; held high until `d_ready`.
- `d_we`  in  1  1 = write, 0 = read.
- `d_addr`  in  32  data byte address.
- `d_wdata`  in  32  write data.
- `d_ready`  out  1  one-cycle completion pulse for the data access.
- `d_rdata`  out  32  read data; valid only while `d_ready`=1 on a read, otherwise 0.
- `mem_en`  out  1  RAM access strobe.
- `mem_we`  out  1  RAM write enable.
- `mem_addr`  out  AW  RAM word address.
- `mem_wdata`  out  32  RAM write data.
- `mem_rdata`  in  32  RAM read data, valid one cycle after the `mem_en` edge.

## Operation
- States: IDLE, ACC_I, ACC_D. Reset state is IDLE.
- **Arbitration in IDLE** (combinational on the current requests):
  - Only `d_req` high: grant D.
  - Only `i_req` high: grant I.
  - Both high: grant I if `wait_cnt`==MAX_WAIT, else grant D.
  - Neither high: stay in IDLE.
- **Issue cycle** (IDLE with a grant):
  - `mem_en`=1.
  - `mem_addr` = granted `addr[AW+1:2]`; `addr[1:0]` and bits above AW+1 are ignored.
  - `mem_we` = `d_we` for a D grant, 0 for an I grant.
  - `mem_wdata` = `d_wdata` for a D grant, 0 otherwise.
  - Next state is ACC_I or ACC_D.
- **Completion cycle** (ACC_I / ACC_D):
  - The matching `*_ready`=1.
  - `*_rdata` = `mem_rdata` (ACC_D write: `d_rdata`=0).
  - `mem_en`=0 and no new issue; next state is always IDLE.
- **`wait_cnt`** (4-bit):
  - Increments on each D grant while `i_req`=1.
  - Clears on an I grant, or in any IDLE cycle with `i_req`=0.
  - Saturates at MAX_WAIT.
- **Requester protocol:**
  - `req`, `addr`, `we` and `wdata` must stay stable from issue through ready.
  - If `req` drops after issue, the access still completes and `ready` still pulses.
  - `req` still high in the cycle after `ready` is a new request.
- Maximum throughput is one access per two cycles.
- All `mem_*` outputs are 0 in IDLE with no grant, in ACC states, and while `reset`=0.

## Timing
- Reset values: state=IDLE, `wait_cnt`=0. All outputs read 0 (`i_ready`, `d_ready`, `i_rdata`, `d_rdata`, `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`).
- Latency from request to ready is 1 cycle when uncontended. A losing requester waits 2 cycles per winning access.
- `mem_*` outputs are combinational from state and requests in the issue cycle. The RAM samples them at the end of that cycle.
- `*_ready` and `*_rdata` are combinational from state and `mem_rdata`. No cycle exists with both readies high.
- **Reset during ACC:**
  - Outputs go to 0 immediately, asynchronously.
  - A write already sampled by the RAM stays written.
  - The aborted requester gets no `ready` and must re-request.
- Simultaneous requests arriving in the completion cycle are held until the next IDLE cycle.

## Test plan
- **Reset:** drive `reset`=0 with `i_req`=`d_req`=1. Require all outputs 0 and `mem_en`=0. After release, the first grant goes to D.
- **Lone fetch:** RAM word 3 = 0xDEADBEEF; `i_req`=1, `i_addr`=0x0000000C.
  - Cycle 0: `mem_en`=1, `mem_addr`=3, `mem_we`=0.
  - Cycle 1: `i_ready`=1, `i_rdata`=0xDEADBEEF.
  - Cycle 2: IDLE.
- **Write/readback:** D write `d_addr`=0x10, `d_wdata`=0x12345678.
  - Require `mem_we`=1, `mem_addr`=4, then `d_ready` with `d_rdata`=0.
  - A following D read of 0x10 returns 0x12345678.
- **Collision:** `i_req` and `d_req` rise in the same cycle.
  - Cycle 0: D issue. Cycle 1: `d_ready`.
  - Cycle 2: I issue. Cycle 3: `i_ready`.
- **Starvation:** MAX_WAIT=4; `i_req` held and `d_req` re-asserted every IDLE cycle. Require 4 D grants, then an I grant on the 5th, then `wait_cnt`=0.
- **Reset mid-access:** assert `reset` in ACC_I. Require `i_ready`=0 immediately, and a fresh 2-cycle fetch after release.
